// File: rtl/uart_frame_parser.sv
// Frame parser behind uart_rx: SYNC, CMD, LEN, payload[LEN], CHK framing with held-frame handshake.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 2080
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic              err_checksum,
    output logic              err_length,
    output logic              err_timeout,
    output logic [7:0]        drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] pay_q [MAX_LEN];
    logic [7:0] pay_d [MAX_LEN];
    logic       frame_valid_q, frame_valid_d;
    logic [7:0] frame_cmd_q, frame_cmd_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic       err_checksum_q, err_checksum_d;
    logic       err_length_q, err_length_d;
    logic       err_timeout_q, err_timeout_d;
    logic [7:0] drop_count_q, drop_count_d;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             in_frame;
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CLKS;
`endif

    // Next-state, datapath and output computation
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        len_d          = len_q;
        chk_d          = chk_q;
        idx_d          = idx_q;
        pay_d          = pay_q;
        frame_cmd_d    = frame_cmd_q;
        frame_len_d    = frame_len_q;
        err_checksum_d = 1'b0;
        err_length_d   = 1'b0;
        err_timeout_d  = 1'b0;
        drop_count_d   = drop_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    chk_d   = rx_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    len_d = rx_data;
                    chk_d = chk_q ^ rx_data;
                    idx_d = 8'd0;
                    if (32'(rx_data) > MAX_LEN) begin
                        err_length_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    pay_d[idx_q[ADDR_W-1:0]] = rx_data;
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        frame_cmd_d = cmd_q;
                        frame_len_d = len_q;
                        state_d     = ST_HOLD;
                    end else begin
                        err_checksum_d = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (rx_valid && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
                if (frame_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef FRAME_TIMEOUT_EN
        // A strobe in the timeout cycle takes priority over the timeout
        gap_d = gap_q;
        if (rx_valid || !in_frame) begin
            gap_d = '0;
        end else if (gap_q == GAP_W'(TIMEOUT_CLKS - 1)) begin
            gap_d         = '0;
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end
`endif

        frame_valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= 8'd0;
            len_q          <= 8'd0;
            chk_q          <= 8'd0;
            idx_q          <= 8'd0;
            frame_valid_q  <= 1'b0;
            frame_cmd_q    <= 8'd0;
            frame_len_q    <= 8'd0;
            err_checksum_q <= 1'b0;
            err_length_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            drop_count_q   <= 8'd0;
            for (int i = 0; i < int'(MAX_LEN); i++) pay_q[i] <= 8'd0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            len_q          <= len_d;
            chk_q          <= chk_d;
            idx_q          <= idx_d;
            frame_valid_q  <= frame_valid_d;
            frame_cmd_q    <= frame_cmd_d;
            frame_len_q    <= frame_len_d;
            err_checksum_q <= err_checksum_d;
            err_length_q   <= err_length_d;
            err_timeout_q  <= err_timeout_d;
            drop_count_q   <= drop_count_d;
            pay_q          <= pay_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_q <= '0;
        else        gap_q <= gap_d;
    end
`endif

    assign rd_data      = (32'(rd_addr) < MAX_LEN) ? pay_q[rd_addr] : 8'h00;
    assign frame_valid  = frame_valid_q;
    assign frame_cmd    = frame_cmd_q;
    assign frame_len    = frame_len_q;
    assign err_checksum = err_checksum_q;
    assign err_length   = err_length_q;
    assign err_timeout  = err_timeout_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; timeout scenario follows FRAME_TIMEOUT_EN.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       err_checksum;
    logic       err_length;
    logic       err_timeout;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    uart_frame_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
        .err_checksum(err_checksum), .err_length(err_length), .err_timeout(err_timeout),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // One strobe per call; returns at the negedge after the sampling posedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_burst(input int n, input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (n) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h expected 00", frame_cmd); end
        checks++; if (frame_len !== 8'h00) begin errors++; $display("FAIL reset_len: got %h expected 00", frame_len); end
        checks++; if ({err_checksum, err_length, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", {err_checksum, err_length, err_timeout}); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop: got %h expected 00", drop_count); end
        rd_addr = 4'd3; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h expected 00", rd_data); end
    endtask

    task automatic test_good_frame();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid: got %b expected 0", frame_valid); end
        send_byte(8'h21);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", frame_valid); end
        checks++; if (frame_cmd !== 8'h10) begin errors++; $display("FAIL good_cmd: got %h expected 10", frame_cmd); end
        checks++; if (frame_len !== 8'h02) begin errors++; $display("FAIL good_len: got %h expected 02", frame_len); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL good_rd0: got %h expected 11", rd_data); end
        rd_addr = 4'd1; #1;
        checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL good_rd1: got %h expected 22", rd_data); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL good_rd5: got %h expected 00", rd_data); end
        ack_frame();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_release: got %b expected 0", frame_valid); end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h20);
        checks++; if (err_checksum !== 1'b1) begin errors++; $display("FAIL chk_pulse: got %b expected 1", err_checksum); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL chk_valid: got %b expected 0", frame_valid); end
        @(negedge clk);
        checks++; if (err_checksum !== 1'b0) begin errors++; $display("FAIL chk_pulse_width: got %b expected 0", err_checksum); end
        send_byte(8'hA5); send_byte(8'h33); send_byte(8'h01); send_byte(8'h44); send_byte(8'h76);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL chk_next_valid: got %b expected 1", frame_valid); end
        checks++; if (frame_cmd !== 8'h33) begin errors++; $display("FAIL chk_next_cmd: got %h expected 33", frame_cmd); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 8'h44) begin errors++; $display("FAIL chk_next_rd0: got %h expected 44", rd_data); end
        ack_frame();
    endtask

    task automatic test_zero_len();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL zlen_valid: got %b expected 1", frame_valid); end
        checks++; if (frame_len !== 8'h00) begin errors++; $display("FAIL zlen_len: got %h expected 00", frame_len); end
        checks++; if (frame_cmd !== 8'h05) begin errors++; $display("FAIL zlen_cmd: got %h expected 05", frame_cmd); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL zlen_drop: got %h expected 00", drop_count); end
        ack_frame();
    endtask

    task automatic test_len_overflow();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        checks++; if (err_length !== 1'b1) begin errors++; $display("FAIL len_pulse: got %b expected 1", err_length); end
        @(negedge clk);
        checks++; if (err_length !== 1'b0) begin errors++; $display("FAIL len_pulse_width: got %b expected 0", err_length); end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        checks++; if ({frame_valid, err_checksum, err_length} !== 3'b000) begin errors++; $display("FAIL len_ignore: got %b expected 000", {frame_valid, err_checksum, err_length}); end
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5C);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL len_next_valid: got %b expected 1", frame_valid); end
    endtask

    task automatic test_hold_drops();
        send_byte(8'h99); send_byte(8'hA5); send_byte(8'h10);
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL hold_drop3: got %0d expected 3", drop_count); end
        checks++; if (frame_cmd !== 8'h07) begin errors++; $display("FAIL hold_cmd: got %h expected 07", frame_cmd); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL hold_rd0: got %h expected 5A", rd_data); end
        @(negedge clk);
        frame_ack = 1'b1; rx_data = 8'h42; rx_valid = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0; rx_valid = 1'b0;
        checks++; if (drop_count !== 8'd4) begin errors++; $display("FAIL hold_ack_drop: got %0d expected 4", drop_count); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", frame_valid); end
        send_byte(8'h55);
        checks++; if (drop_count !== 8'd4) begin errors++; $display("FAIL idle_no_drop: got %0d expected 4", drop_count); end
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5C);
        send_burst(300, 8'hEE);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL hold_saturate: got %0d expected 255", drop_count); end
        ack_frame();
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int seen_at;
        seen_at = 0;
        send_byte(8'hA5); send_byte(8'h10);
        for (int n = 1; n <= 2200 && seen_at == 0; n++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) seen_at = n;
        end
        checks++; if (seen_at !== 2080) begin errors++; $display("FAIL timeout_cycle: got %0d expected 2080", seen_at); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b expected 0", err_timeout); end
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL timeout_recover: got %b expected 1", frame_valid); end
        ack_frame();
    endtask
`else
    task automatic test_timeout();
        logic seen;
        seen = 1'b0;
        send_byte(8'hA5); send_byte(8'h10);
        repeat (2200) begin
            @(negedge clk);
            if (err_timeout !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_timeout: got %b expected 0", seen); end
        send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL wait_forever_valid: got %b expected 1", frame_valid); end
        ack_frame();
    endtask
`endif

    task automatic test_reset_mid_payload();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL rst_mid_drop: got %h expected 00", drop_count); end
        checks++; if (frame_cmd !== 8'h00) begin errors++; $display("FAIL rst_mid_cmd: got %h expected 00", frame_cmd); end
        checks++; if ({frame_valid, err_checksum, err_length, err_timeout} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {frame_valid, err_checksum, err_length, err_timeout}); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rd0: got %h expected 00", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rst_recover_valid: got %b expected 1", frame_valid); end
        rd_addr = 4'd1; #1;
        checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL rst_recover_rd1: got %h expected 22", rd_data); end
        ack_frame();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_len();
        test_len_overflow();
        test_hold_drops();
        test_timeout();
        test_reset_mid_payload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Byte-level framing stage directly downstream of uart_rx. It consumes the uart_rx data_out/data_valid byte stream and recognises frames of the form SYNC, CMD, LEN, payload[LEN], CHK. Each frame's payload is buffered in a small register file. A checksum-verified frame is presented to the command logic through a valid/ack handshake with random-access payload read.

Parameters:
MAX_LEN, 16, maximum payload bytes; buffer depth.
ADDR_W, 4, payload read address width; must satisfy 2**ADDR_W >= MAX_LEN.
SYNC_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CLKS, 2080, inter-byte timeout in clk cycles (2 byte times at 104 clk/bit). Used only with FRAME_TIMEOUT_EN.

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from uart_rx data_out
rx_valid  in  1  one-cycle strobe from uart_rx data_valid
frame_valid  out  1  verified frame held for consumer
frame_cmd  out  8  CMD byte of held frame
frame_len  out  8  LEN byte of held frame
rd_addr  in  ADDR_W  payload read index
rd_data  out  8  payload byte at rd_addr; combinational read
frame_ack  in  1  consumer releases held frame
err_checksum  out  1  one-cycle pulse: CHK mismatch
err_length  out  1  one-cycle pulse: LEN > MAX_LEN
err_timeout  out  1  one-cycle pulse: inter-byte gap exceeded
drop_count  out  8  saturating count of bytes dropped while holding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - frame_valid, frame_cmd, frame_len, all err_* and drop_count are 0.
  - Payload buffer cleared to 0.
  - Any partial frame is discarded.
- States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. Transitions occur only on rx_valid, except the HOLD exit and the timeout.
- IDLE:
  - rx_data==SYNC_BYTE -> CMD.
  - Any other byte is ignored silently; drop_count is not affected.
- CMD: latch cmd; running checksum = rx_data -> LEN.
- LEN: latch len; checksum ^= rx_data.
  - len > MAX_LEN -> err_length pulse, go to IDLE.
  - len == 0 -> CHK.
  - Otherwise idx=0 -> PAYLOAD.
- PAYLOAD:
  - buf[idx] <= rx_data; checksum ^= rx_data; idx++.
  - After the byte written at idx==len-1 -> CHK.
- CHK: checksum = XOR of CMD, LEN and all payload bytes.
  - rx_data==checksum -> HOLD. frame_valid rises on the cycle after that rx_valid (1-cycle latency).
  - Mismatch -> err_checksum pulse on the same 1-cycle latency, go to IDLE.
- A SYNC_BYTE value seen inside CMD/LEN/PAYLOAD/CHK is treated as data; there is no resync.
- HOLD:
  - frame_valid=1. frame_cmd, frame_len and buffer contents stay stable; the buffer is never written outside PAYLOAD.
  - frame_ack=1 -> frame_valid=0 next cycle, go to IDLE.
  - rx_valid in HOLD, including the ack cycle: byte dropped, drop_count++, saturating at 255.
- frame_cmd/frame_len keep their last values after release. frame_len is meaningful only while frame_valid=1.
- rd_data = buf[rd_addr] when rd_addr < MAX_LEN, else 8'h00. Reads are valid in any state.
- frame_ack outside HOLD is ignored.
- Error pulses are mutually exclusive, each lasting exactly one cycle.

Optional Feature:
FRAME_TIMEOUT_EN:
- Defined:
  - Gap counter cleared on every rx_valid; counts only in CMD/LEN/PAYLOAD/CHK.
  - On reaching TIMEOUT_CLKS with no rx_valid: err_timeout pulse, go to IDLE, partial frame discarded.
  - rx_valid in the same cycle as the timeout wins; the byte is processed and the counter clears.
- Undefined:
  - No counter; err_timeout tied to 0.
  - The parser waits indefinitely mid-frame.

Test Plan:
- Good frame: rx bytes A5 10 02 11 22 21 -> frame_valid=1 one cycle after the last strobe, frame_cmd=10, frame_len=02, rd_addr 0/1 -> 11/22. frame_ack -> frame_valid=0 next cycle.
- Bad checksum: A5 10 02 11 22 20 -> err_checksum single pulse, frame_valid stays 0. A following good frame is accepted.
- Zero length plus leading garbage: 00 FF A5 05 00 05 -> frame_valid=1, frame_len=0, frame_cmd=05, drop_count=0.
- Length overflow: A5 01 11 (17 > MAX_LEN=16) -> err_length pulse after the LEN strobe. Following bytes are ignored until the next A5.
- Hold-time drops: good frame held, 3 bytes sent before frame_ack -> drop_count=3. Payload readback unchanged; 300 dropped bytes -> drop_count saturates at 255.
- Timeout / reset (FRAME_TIMEOUT_EN): A5 10 then gap of 2080 clk -> err_timeout pulse, then A5 10 02 11 22 21 is parsed OK. Asserting rst_n=0 mid-PAYLOAD -> all outputs 0 immediately.
